// File: rtl/regfile_pkg.sv
// Shared types and width helpers for the register-file write arbiter.
package regfile_pkg;

  localparam int unsigned MaxAddrWidth = 16;
  localparam int unsigned MaxDataWidth = 64;

  // Both helpers keep a 1-bit minimum so tiny configurations still have legal vectors.
  function automatic int unsigned addr_width(input int unsigned num_entries);
    return (num_entries > 2) ? $clog2(num_entries) : 1;
  endfunction

  function automatic int unsigned idx_width(input int unsigned num_requesters);
    return (num_requesters > 2) ? $clog2(num_requesters) : 1;
  endfunction

  typedef struct packed {
    logic [MaxAddrWidth-1:0] addr;
    logic [MaxDataWidth-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after the priority pointer.
module rr_arbiter #(
  parameter int unsigned NumReq   = 4,
  parameter int unsigned IdxWidth = 2
) (
  input  logic                clk,
  input  logic                rst_ni,
  input  logic [NumReq-1:0]   req_i,
  input  logic                en_i,
  output logic [NumReq-1:0]   gnt_o,
  output logic [IdxWidth-1:0] gnt_idx_o
);

  logic [IdxWidth-1:0] ptr_q, ptr_d;
  logic [IdxWidth:0]   sum;
  logic [IdxWidth-1:0] idx;
  logic                found;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      // ptr_q < NumReq and k < NumReq, so a single subtract folds the sum back into range.
      sum = {1'b0, ptr_q} + (IdxWidth+1)'(k);
      if (sum >= (IdxWidth+1)'(NumReq)) begin
        sum = sum - (IdxWidth+1)'(NumReq);
      end
      idx = sum[IdxWidth-1:0];
      if (!found && en_i && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = idx;
        found      = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (found) begin
      ptr_d = (gnt_idx_o == IdxWidth'(NumReq - 1)) ? '0 : gnt_idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Arbitrates N write requesters onto a single register-file write port, one write per cycle,
// with a one-cycle registered output stage.
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned DataWidth     = 8,
  parameter int unsigned NumEntries    = 4,
  parameter int unsigned NumRequesters = 4,
  localparam int unsigned AddressWidth = addr_width(NumEntries),
  localparam int unsigned IdxWidth     = idx_width(NumRequesters)
) (
  input  logic                                        clk,
  input  logic                                        rst_ni,
  input  logic [NumRequesters-1:0]                    req_valid_i,
  output logic [NumRequesters-1:0]                    req_ready_o,
  input  logic [NumRequesters-1:0][AddressWidth-1:0]  req_addr_i,
  input  logic [NumRequesters-1:0][DataWidth-1:0]     req_data_i,
  input  logic                                        stall_i,
  output logic                                        rf_wen_o,
  output logic [AddressWidth-1:0]                     rf_waddr_o,
  output logic [DataWidth-1:0]                        rf_wdata_o,
  output logic [IdxWidth-1:0]                         grant_idx_o
);

  logic [NumRequesters-1:0] gnt;
  logic [IdxWidth-1:0]      gnt_idx;
  logic                     transfer;

  logic                    wen_q;
  logic [AddressWidth-1:0] waddr_q;
  logic [DataWidth-1:0]    wdata_q;
  logic [IdxWidth-1:0]     idx_q;

  rr_arbiter #(
    .NumReq   (NumRequesters),
    .IdxWidth (IdxWidth)
  ) u_rr_arbiter (
    .clk       (clk),
    .rst_ni    (rst_ni),
    .req_i     (req_valid_i),
    .en_i      (~stall_i),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign req_ready_o = gnt;
  assign transfer    = |(req_valid_i & gnt);

  // Address/data/index only move on a transfer so they hold their last values when idle.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      idx_q   <= '0;
    end else begin
      wen_q <= transfer;
      if (transfer) begin
        waddr_q <= req_addr_i[gnt_idx];
        wdata_q <= req_data_i[gnt_idx];
        idx_q   <= gnt_idx;
      end
    end
  end

  assign rf_wen_o    = wen_q;
  assign rf_waddr_o  = waddr_q;
  assign rf_wdata_o  = wdata_q;
  assign grant_idx_o = idx_q;

endmodule

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 SHALL have parameter DataWidth, default 8, the write-data width in bits.
REQ-002 SHALL have parameter NumEntries, default 4, the register-file depth.
REQ-003 SHALL have parameter NumRequesters, default 4, the number of write requesters (legal values 2..16).
REQ-004 SHALL have localparam AddressWidth = (NumEntries>2) ? $clog2(NumEntries) : 1.
REQ-005 SHALL have localparam IdxWidth = (NumRequesters>2) ? $clog2(NumRequesters) : 1.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge.
REQ-007 SHALL have port rst_ni, input, 1 bit: the reset, asynchronous and active-low.
REQ-008 SHALL have port req_valid_i, input, NumRequesters bits: per-requester write request.
REQ-009 SHALL have port req_ready_o, output, NumRequesters bits: per-requester accept.
REQ-010 SHALL have port req_addr_i, input, NumRequesters x AddressWidth: per-requester write address.
REQ-011 SHALL have port req_data_i, input, NumRequesters x DataWidth: per-requester write data.
REQ-012 SHALL have port stall_i, input, 1 bit: downstream write port unavailable this cycle.
REQ-013 SHALL have port rf_wen_o, output, 1 bit: write enable to the register file.
REQ-014 SHALL have port rf_waddr_o, output, AddressWidth: write address to the register file.
REQ-015 SHALL have port rf_wdata_o, output, DataWidth: write data to the register file.
REQ-016 SHALL have port grant_idx_o, output, IdxWidth: index of the requester whose write is on rf_*_o.

Function
REQ-017 SHALL keep a priority pointer ptr (IdxWidth bits); the candidate is the first i with req_valid_i[i]=1, searching ptr, ptr+1, ... mod NumRequesters.
REQ-018 SHALL drive req_ready_o[i]=1 only for the candidate and only when stall_i=0; all other bits 0, combinationally.
REQ-019 SHALL define transfer as req_valid_i[i] & req_ready_o[i]; at most one transfer per cycle.
REQ-020 SHALL, on transfer by i, set ptr <= (i+1) mod NumRequesters; otherwise hold ptr.
REQ-021 SHALL register the transfer: next cycle rf_wen_o=1, rf_waddr_o/rf_wdata_o = the transferred address/data, grant_idx_o=i (latency exactly 1 cycle).
REQ-022 SHALL drive rf_wen_o=0 in any cycle following a cycle without a transfer; rf_waddr_o, rf_wdata_o, grant_idx_o hold their last values.
REQ-023 SHALL, with stall_i=1, make no transfer, hold ptr, and drive rf_wen_o=0 the following cycle.
REQ-024 SHALL tolerate requesters holding valid/addr/data stable until ready; a requester dropping valid before ready loses no state and causes no write.
REQ-025 SHALL produce no write and no ptr change when req_valid_i is all zero.
REQ-026 SHALL guarantee each continuously-valid requester a transfer within NumRequesters non-stalled cycles.
REQ-027 SHALL forward two accepted writes to the same address in acceptance order; no merging or dropping.
REQ-028 SHALL wrap ptr from NumRequesters-1 to 0.

Reset
REQ-029 SHALL, while rst_ni=0, asynchronously force ptr=0, rf_wen_o=0, rf_waddr_o=0, rf_wdata_o=0, grant_idx_o=0.
REQ-030 SHALL discard a write accepted in the cycle reset asserts; no rf_wen_o pulse after reset release without a new transfer.
REQ-031 SHALL keep req_ready_o combinational during reset (it may be 1); requesters SHALL treat no transfer as occurring while rst_ni=0.

Structure
REQ-032 SHALL place AddressWidth/IdxWidth derivation helpers and a write-request struct type (addr, data) in shared package regfile_pkg.
REQ-033 SHALL implement the pointer and priority search in a sub-module rr_arbiter (inputs: request vector, enable, outputs: one-hot grant, grant index), and the output register stage in regfile_wr_arbiter.

Verification
REQ-034 SHALL cover reset: rst_ni=0 mid-traffic -> rf_wen_o=0, grant_idx_o=0 immediately; first grant after release goes to lowest valid index.
REQ-035 SHALL cover single requester: req_valid_i=4'b0100, addr=2, data=8'hA5 -> ready[2]=1 same cycle; next cycle rf_wen_o=1, rf_waddr_o=2, rf_wdata_o=8'hA5, grant_idx_o=2.
REQ-036 SHALL cover fairness: req_valid_i=4'b1111 held 8 cycles -> grant order 0,1,2,3,0,1,2,3, one rf_wen_o pulse per cycle.
REQ-037 SHALL cover stall: all valid, stall_i=1 for 3 cycles mid-sequence -> req_ready_o=0, rf_wen_o=0 for those cycles, order resumes at same index.
REQ-038 SHALL cover wrap and skip: ptr=3, req_valid_i=4'b0011 -> grant 0 then 1, ptr ends at 2.
REQ-039 SHALL cover same-address ordering: requester 1 writes addr 3=8'h11 then requester 2 writes addr 3=8'h22 -> rf_wdata_o sequence 8'h11, 8'h22.
